// File: rtl/pubkey_streamer_if.sv
// Read port toward the systemizer block memory plus the public-key output stream.
interface pubkey_streamer_if #(
  parameter int W  = 12,
  parameter int AW = 5
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          pk_valid;
  logic          pk_ready;
  logic [W-1:0]  pk_data;
  logic          pk_last;

  modport master (
    output rd_en, rd_addr, pk_valid, pk_data, pk_last,
    input  rd_data, pk_ready
  );
  modport slave (
    input  rd_en, rd_addr, pk_valid, pk_data, pk_last,
    output rd_data, pk_ready
  );
endinterface

// File: rtl/pubkey_streamer.sv
// Streams the non-identity columns of the systemized matrix out of the systemizer
// memory as BLOCK-element words, row by row, through a 2-entry skid FIFO.
module pubkey_streamer #(
  parameter int L     = 8,
  parameter int K     = 16,
  parameter int M     = 3,
  parameter int BLOCK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sys_done,
  input  logic              sys_success,
  pubkey_streamer_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int W      = BLOCK * M;
  localparam int AW     = $clog2(L * K / BLOCK);
  localparam int NWORDS = L * (K - L) / BLOCK;
  localparam int CW     = $clog2(NWORDS + 1);
  localparam int BW     = $clog2(K / BLOCK + 1);

  localparam logic [CW-1:0] LAST_WORD  = CW'(NWORDS - 1);
  localparam logic [CW-1:0] ALL_WORDS  = CW'(NWORDS);
  localparam logic [BW-1:0] BLK_FIRST  = BW'(L / BLOCK);
  localparam logic [BW-1:0] BLK_LAST   = BW'(K / BLOCK - 1);
  localparam logic [AW-1:0] ADDR_FIRST = AW'(L / BLOCK);
  localparam logic [AW-1:0] ROW_SKIP   = AW'(L / BLOCK + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARM    = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  logic [1:0]          state;
  logic [CW-1:0]       rd_cnt;
  logic [CW-1:0]       out_cnt;
  logic [BW-1:0]       blk;
  logic [AW-1:0]       addr;
  logic                rd_infl;
  logic [1:0][W-1:0]   fifo_mem;
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          occ;
  logic                valid;
  logic                pop;
  logic                room;
  logic                issue;

  // Issue only if the word still in flight plus the FIFO contents, less this
  // cycle's pop, leaves a free slot for the data this read will return.
  always_comb begin
    valid = (occ != 2'd0);
    pop   = valid & bus.pk_ready;
    room  = ({1'b0, occ} + {2'b0, rd_infl}) < (3'd2 + {2'b0, pop});
    issue = (state == S_STREAM) && (rd_cnt != ALL_WORDS) && room;
  end

  assign bus.rd_en    = issue;
  assign bus.rd_addr  = addr;
  assign bus.pk_valid = valid;
  assign bus.pk_data  = valid ? fifo_mem[rd_ptr] : '0;
  assign bus.pk_last  = valid && (out_cnt == LAST_WORD);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_FINISH);

  always_ff @(posedge clk) begin
    if (rd_infl) fifo_mem[wr_ptr] <= bus.rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      rd_cnt  <= '0;
      out_cnt <= '0;
      blk     <= '0;
      addr    <= '0;
      rd_infl <= 1'b0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      occ     <= 2'd0;
      error   <= 1'b0;
    end else begin
      error   <= 1'b0;
      rd_infl <= issue;
      if (rd_infl) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, rd_infl} - {1'b0, pop};
      if (pop) out_cnt <= out_cnt + 1'b1;

      // Address walks the right-hand blocks of each row; it holds after the final read.
      if (issue) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_cnt != LAST_WORD) begin
          if (blk == BLK_LAST) begin
            blk  <= BLK_FIRST;
            addr <= addr + ROW_SKIP;
          end else begin
            blk  <= blk + 1'b1;
            addr <= addr + 1'b1;
          end
        end
      end

      case (state)
        S_IDLE:   if (start) state <= S_ARM;
        S_ARM: begin
          if (sys_done) begin
            if (sys_success) begin
              state   <= S_STREAM;
              rd_cnt  <= '0;
              out_cnt <= '0;
              blk     <= BLK_FIRST;
              addr    <= ADDR_FIRST;
              wr_ptr  <= 1'b0;
              rd_ptr  <= 1'b0;
              occ     <= 2'd0;
            end else begin
              error <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        S_STREAM: if (pop && (out_cnt == LAST_WORD)) state <= S_FINISH;
        default:  state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pubkey_streamer.sv
// Directed-plus-random bench for pubkey_streamer against a memory model and a
// reference word order derived from row/block arithmetic.
module tb_pubkey_streamer;
  localparam int L = 8, K = 16, M = 3, BLOCK = 4;
  localparam int W = BLOCK * M;
  localparam int AW = $clog2(L * K / BLOCK);
  localparam int NW = L * (K - L) / BLOCK;
  localparam int MW = L * K / BLOCK;

  logic clk = 1'b0;
  logic rst, start, sys_done, sys_success;
  logic busy, done, error;

  pubkey_streamer_if #(.W(W), .AW(AW)) bus();

  pubkey_streamer #(.L(L), .K(K), .M(M), .BLOCK(BLOCK)) dut (
    .clk(clk), .rst(rst), .start(start), .sys_done(sys_done),
    .sys_success(sys_success), .bus(bus), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [0:MW-1];

  // Systemizer memory: data one cycle after rd_en, garbage otherwise.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    else           bus.rd_data <= W'($urandom);
  end

  int errors = 0, checks = 0, cyc = 0, t0 = 0;
  logic [AW-1:0] addr_q[$];
  int            rd_cyc[$];
  logic [W-1:0]  hs_data[$];
  bit            hs_last[$];
  int            hs_cyc[$];
  int            done_cyc[$];
  int  err_pulses, valid_cnt, busy_low, stab_err, max_out, outstanding;
  bit  track_busy, rand_ready, prev_stall, prev_last;
  logic [W-1:0] prev_data;
  logic s_rd_en, s_valid, s_last, s_busy, s_done, s_error;
  logic [AW-1:0] s_rd_addr;
  logic [W-1:0]  s_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_addr(input int i);
    int per;
    per = K / BLOCK - L / BLOCK;
    return (i / per) * (K / BLOCK) + L / BLOCK + (i % per);
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < MW; i++) mem[i] = W'($urandom);
  endtask

  task automatic clear_log();
    addr_q.delete(); rd_cyc.delete(); hs_data.delete(); hs_last.delete();
    hs_cyc.delete(); done_cyc.delete();
    err_pulses = 0; valid_cnt = 0; busy_low = 0; stab_err = 0;
    max_out = 0; outstanding = 0; prev_stall = 0;
  endtask

  // Sample mid-cycle, log events, then advance past the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    s_rd_en = bus.rd_en; s_rd_addr = bus.rd_addr; s_valid = bus.pk_valid;
    s_data = bus.pk_data; s_last = bus.pk_last; s_busy = busy; s_done = done; s_error = error;
    if (!rst) begin
      if (prev_stall && (!s_valid || s_data !== prev_data || s_last !== prev_last)) stab_err++;
      if (s_rd_en) begin addr_q.push_back(s_rd_addr); rd_cyc.push_back(cyc); outstanding++; end
      if (s_valid && bus.pk_ready) begin
        hs_data.push_back(s_data); hs_last.push_back(s_last); hs_cyc.push_back(cyc); outstanding--;
      end
      if (outstanding > max_out) max_out = outstanding;
      if (s_valid) valid_cnt++;
      if (s_done) done_cyc.push_back(cyc);
      if (s_error) err_pulses++;
      if (track_busy && !s_busy) busy_low++;
      prev_stall = s_valid && !bus.pk_ready; prev_data = s_data; prev_last = s_last;
    end else prev_stall = 0;
    @(posedge clk); #1;
    if (rand_ready) bus.pk_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic launch(input bit succ);
    clear_log();
    start = 1; tick(); start = 0;
    track_busy = succ;
    tick(); tick();
    sys_done = 1; sys_success = succ; tick(); t0 = cyc;
    sys_done = 0; sys_success = 0;
  endtask

  task automatic finish_run(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cyc.size() == 0 && n < budget) begin tick(); n++; end
    track_busy = 0;
    chk({tag, "_done_seen"}, done_cyc.size() > 0, 1);
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_nreads"}, addr_q.size(), NW);
    chk({tag, "_nhs"}, hs_data.size(), NW);
    for (int i = 0; i < NW && i < addr_q.size(); i++)
      chk($sformatf("%s_addr%0d", tag, i), addr_q[i], exp_addr(i));
    for (int i = 0; i < NW && i < hs_data.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), hs_data[i], mem[exp_addr(i)]);
      chk($sformatf("%s_last%0d", tag, i), hs_last[i], (i == NW - 1));
    end
    chk({tag, "_ndone"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0 && hs_cyc.size() > 0)
      chk({tag, "_done_after_last"}, done_cyc[0], hs_cyc[hs_cyc.size()-1] + 1);
    chk({tag, "_busy"}, busy_low, 0);
    chk({tag, "_stable"}, stab_err, 0);
    chk({tag, "_maxocc"}, max_out <= 2, 1);
    chk({tag, "_noerr"}, err_pulses, 0);
  endtask

  initial begin
    rst = 1; start = 0; sys_done = 0; sys_success = 0;
    bus.pk_ready = 1; rand_ready = 0; track_busy = 0;
    clear_log(); fill_mem();

    // Reset state
    tick(); tick();
    chk("rst_rd_en", s_rd_en, 0);     chk("rst_rd_addr", s_rd_addr, 0);
    chk("rst_valid", s_valid, 0);     chk("rst_data", s_data, 0);
    chk("rst_last", s_last, 0);       chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);       chk("rst_error", s_error, 0);
    rst = 0; tick();

    // Nominal, ready held high, cycle-exact timing
    launch(1);
    finish_run("nom", 100);
    check_stream("nom");
    chk("nom_first_rd", rd_cyc.size() > 0 ? rd_cyc[0] : -1, t0 + 1);
    chk("nom_first_hs", hs_cyc.size() > 0 ? hs_cyc[0] : -1, t0 + 3);
    chk("nom_last_hs", hs_cyc.size() > 0 ? hs_cyc[hs_cyc.size()-1] : -1, t0 + NW + 2);
    chk("nom_done_cyc", done_cyc.size() > 0 ? done_cyc[0] : -1, t0 + NW + 3);
    tick();
    chk("nom_idle", s_busy, 0);

    // Random 50% backpressure
    fill_mem(); rand_ready = 1;
    launch(1);
    finish_run("bp", 400);
    check_stream("bp");
    rand_ready = 0; bus.pk_ready = 1; tick();

    // Stalled from the start
    fill_mem(); bus.pk_ready = 0;
    launch(1);
    for (int i = 0; i < 20; i++) tick();
    chk("stall_nreads", addr_q.size(), 2);
    chk("stall_addr0", addr_q.size() > 0 ? addr_q[0] : '1, exp_addr(0));
    chk("stall_valid", s_valid, 1);
    chk("stall_data", s_data, mem[exp_addr(0)]);
    chk("stall_rd_low", s_rd_en, 0);
    bus.pk_ready = 1;
    finish_run("stall", 100);
    check_stream("stall");
    tick();

    // Systemization failure
    launch(0);
    tick();
    chk("fail_err_pulse", s_error, 1);
    chk("fail_idle", s_busy, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("fail_nerr", err_pulses, 1);
    chk("fail_nreads", addr_q.size(), 0);
    chk("fail_nvalid", valid_cnt, 0);
    chk("fail_busy", s_busy, 0);

    // Reset after 5 handshakes, then a clean re-run
    fill_mem();
    launch(1);
    for (int n = 0; n < 40 && hs_data.size() < 5; n++) tick();
    chk("mid_hs5", hs_data.size(), 5);
    rst = 1; tick(); rst = 0; track_busy = 0; tick();
    chk("mid_rd_en", s_rd_en, 0);   chk("mid_rd_addr", s_rd_addr, 0);
    chk("mid_valid", s_valid, 0);   chk("mid_data", s_data, 0);
    chk("mid_last", s_last, 0);     chk("mid_busy", s_busy, 0);
    chk("mid_done", s_done, 0);     chk("mid_error", s_error, 0);
    tick(); tick();
    launch(1);
    finish_run("rerun", 100);
    check_stream("rerun");
    tick();

    // start and sys_done pulsed during STREAM are ignored
    fill_mem(); rand_ready = 1;
    launch(1);
    for (int i = 0; i < 4; i++) tick();
    start = 1; tick(); start = 0;
    tick(); tick();
    sys_done = 1; sys_success = 0; tick(); sys_done = 0;
    finish_run("ign", 400);
    check_stream("ign");
    rand_ready = 0; bus.pk_ready = 1;
    for (int i = 0; i < 5; i++) tick();
    chk("ign_idle", s_busy, 0);
    chk("ign_no_rearm", addr_q.size(), NW);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
